// File: rtl/uart_core.sv
// uart_core: full-duplex UART engine with a shared runtime baud generator, a transmitter and an oversampling receiver.
// Latency: the TX line falls 1..I_BAUD_DIV+1 clocks after acceptance; O_RX_VALID rises 1 cycle after the stop-bit mid-sample.
// Backpressure: O_TX_READY stays low for the whole TX frame; RX has no buffer, so O_RX_VALID must be consumed on its pulse.
// Ports: I_CLK/I_RSTF clock and async active-low reset; I_BAUD_DIV tick period-1; I_PARITY_EN/I_PARITY_ODD/I_TWO_STOP frame format;
//        I_LOOPBACK routes TX into RX and holds O_TX high; I_TX_DATA/I_TX_VALID/O_TX_READY TX handshake; O_TX serial out;
//        I_RX serial in; O_RX_DATA/O_RX_VALID/O_RX_FRAME_ERR/O_RX_PARITY_ERR received word and its error flags.
module uart_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 I_CLK,
    input  logic                 I_RSTF,
    input  logic [DIV_WIDTH-1:0] I_BAUD_DIV,
    input  logic                 I_PARITY_EN,
    input  logic                 I_PARITY_ODD,
    input  logic                 I_TWO_STOP,
    input  logic                 I_LOOPBACK,
    input  logic [DATA_BITS-1:0] I_TX_DATA,
    input  logic                 I_TX_VALID,
    output logic                 O_TX_READY,
    output logic                 O_TX,
    input  logic                 I_RX,
    output logic [DATA_BITS-1:0] O_RX_DATA,
    output logic                 O_RX_VALID,
    output logic                 O_RX_FRAME_ERR,
    output logic                 O_RX_PARITY_ERR
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_MID    = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    // Baud generator: '>=' lets a lowered divisor take effect on the very next cycle.
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic                 tick;
    assign tick = (baud_cnt >= I_BAUD_DIV);

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF)   baud_cnt <= '0;
        else if (tick) baud_cnt <= '0;
        else           baud_cnt <= baud_cnt + DIV_WIDTH'(1);
    end

    // ---------------- Transmitter ----------------
    // TX_WAIT holds the line idle until the first tick so every bit is a whole number of ticks.
    typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    tx_state_t            tx_state, tx_state_n;
    logic [TW-1:0]        tx_tick, tx_tick_n;
    logic [IW-1:0]        tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_par, tx_par_n, tx_par_en, tx_par_en_n;
    logic                 tx_two, tx_two_n, tx_line, tx_line_n;
    logic                 tx_bit_end;

    assign tx_bit_end = tick && (tx_tick == T_LAST);

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            tx_state  <= TX_IDLE;
            tx_tick   <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            tx_par_en <= 1'b0;
            tx_two    <= 1'b0;
            tx_line   <= 1'b1;
        end else begin
            tx_state  <= tx_state_n;
            tx_tick   <= tx_tick_n;
            tx_idx    <= tx_idx_n;
            tx_shift  <= tx_shift_n;
            tx_par    <= tx_par_n;
            tx_par_en <= tx_par_en_n;
            tx_two    <= tx_two_n;
            tx_line   <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n  = tx_state;
        tx_tick_n   = tx_tick;
        tx_idx_n    = tx_idx;
        tx_shift_n  = tx_shift;
        tx_par_n    = tx_par;
        tx_par_en_n = tx_par_en;
        tx_two_n    = tx_two;
        tx_line_n   = tx_line;
        if (tick && tx_state != TX_IDLE && tx_state != TX_WAIT)
            tx_tick_n = tx_bit_end ? '0 : tx_tick + TW'(1);
        case (tx_state)
            TX_IDLE: begin
                tx_line_n = 1'b1;
                if (I_TX_VALID) begin
                    tx_state_n  = TX_WAIT;
                    tx_shift_n  = I_TX_DATA;
                    tx_par_n    = (^I_TX_DATA) ^ I_PARITY_ODD;
                    tx_par_en_n = I_PARITY_EN;
                    tx_two_n    = I_TWO_STOP;
                end
            end
            TX_WAIT: if (tick) begin
                tx_state_n = TX_START;
                tx_line_n  = 1'b0;
                tx_tick_n  = '0;
            end
            TX_START: if (tx_bit_end) begin
                tx_state_n = TX_DATA;
                tx_idx_n   = '0;
                tx_line_n  = tx_shift[0];
            end
            TX_DATA: if (tx_bit_end) begin
                if (tx_idx == IDX_LAST) begin
                    tx_idx_n = '0;
                    if (tx_par_en) begin
                        tx_state_n = TX_PARITY;
                        tx_line_n  = tx_par;
                    end else begin
                        tx_state_n = TX_STOP;
                        tx_line_n  = 1'b1;
                    end
                end else begin
                    tx_idx_n   = tx_idx + IW'(1);
                    tx_shift_n = tx_shift >> 1;
                    tx_line_n  = tx_shift[1];
                end
            end
            TX_PARITY: if (tx_bit_end) begin
                tx_state_n = TX_STOP;
                tx_line_n  = 1'b1;
            end
            TX_STOP: if (tx_bit_end) begin
                // tx_idx counts stop bits already sent.
                if (tx_two && tx_idx == '0) tx_idx_n = IW'(1);
                else                        tx_state_n = TX_IDLE;
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    assign O_TX_READY = (tx_state == TX_IDLE);
    assign O_TX       = I_LOOPBACK | tx_line;

    // ---------------- Receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_t;
    rx_state_t            rx_state, rx_state_n;
    logic                 rx_sync1, rx_line;
    logic [TW-1:0]        rx_tick, rx_tick_n;
    logic [IW-1:0]        rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n, rx_data_q, rx_data_n;
    logic                 rx_par_en, rx_par_en_n, rx_odd, rx_odd_n, rx_par_bad, rx_par_bad_n;
    logic                 rx_vld_q, rx_vld_n, rx_ferr_q, rx_ferr_n, rx_perr_q, rx_perr_n;
    logic                 rx_bit_end;

    assign rx_bit_end = tick && (rx_tick == T_LAST);

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            rx_sync1   <= 1'b1;
            rx_line    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_tick    <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_data_q  <= '0;
            rx_par_en  <= 1'b0;
            rx_odd     <= 1'b0;
            rx_par_bad <= 1'b0;
            rx_vld_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_sync1   <= I_LOOPBACK ? tx_line : I_RX;
            rx_line    <= rx_sync1;
            rx_state   <= rx_state_n;
            rx_tick    <= rx_tick_n;
            rx_idx     <= rx_idx_n;
            rx_shift   <= rx_shift_n;
            rx_data_q  <= rx_data_n;
            rx_par_en  <= rx_par_en_n;
            rx_odd     <= rx_odd_n;
            rx_par_bad <= rx_par_bad_n;
            rx_vld_q   <= rx_vld_n;
            rx_ferr_q  <= rx_ferr_n;
            rx_perr_q  <= rx_perr_n;
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        rx_tick_n    = rx_tick;
        rx_idx_n     = rx_idx;
        rx_shift_n   = rx_shift;
        rx_data_n    = rx_data_q;
        rx_par_en_n  = rx_par_en;
        rx_odd_n     = rx_odd;
        rx_par_bad_n = rx_par_bad;
        rx_vld_n     = 1'b0;
        rx_ferr_n    = 1'b0;
        rx_perr_n    = 1'b0;
        if (tick && (rx_state == RX_DATA || rx_state == RX_PARITY || rx_state == RX_STOP))
            rx_tick_n = rx_bit_end ? '0 : rx_tick + TW'(1);
        case (rx_state)
            RX_IDLE: if (tick && !rx_line) begin
                rx_state_n = RX_START;
                rx_tick_n  = '0;
            end
            RX_START: if (tick) begin
                if (rx_tick == T_MID) begin
                    // Mid start bit: high means a glitch, drop it silently.
                    rx_tick_n = '0;
                    if (rx_line) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n   = RX_DATA;
                        rx_idx_n     = '0;
                        rx_par_en_n  = I_PARITY_EN;
                        rx_odd_n     = I_PARITY_ODD;
                        rx_par_bad_n = 1'b0;
                    end
                end else begin
                    rx_tick_n = rx_tick + TW'(1);
                end
            end
            RX_DATA: if (rx_bit_end) begin
                rx_shift_n = {rx_line, rx_shift[DATA_BITS-1:1]};
                if (rx_idx == IDX_LAST) begin
                    rx_idx_n   = '0;
                    rx_state_n = rx_par_en ? RX_PARITY : RX_STOP;
                end else begin
                    rx_idx_n = rx_idx + IW'(1);
                end
            end
            RX_PARITY: if (rx_bit_end) begin
                rx_par_bad_n = rx_line ^ (^rx_shift) ^ rx_odd;
                rx_state_n   = RX_STOP;
            end
            RX_STOP: if (rx_bit_end) begin
                rx_vld_n   = 1'b1;
                rx_data_n  = rx_shift;
                rx_ferr_n  = !rx_line;
                rx_perr_n  = rx_par_bad;
                // A bad stop bit waits for the line to recover so a break gives one word.
                rx_state_n = rx_line ? RX_IDLE : RX_WAIT_IDLE;
            end
            RX_WAIT_IDLE: if (rx_line) rx_state_n = RX_IDLE;
            default: rx_state_n = RX_IDLE;
        endcase
    end

    assign O_RX_DATA       = rx_data_q;
    assign O_RX_VALID      = rx_vld_q;
    assign O_RX_FRAME_ERR  = rx_ferr_q;
    assign O_RX_PARITY_ERR = rx_perr_q;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed plus randomized checks of uart_core (8-bit instance and a 5-bit instance looped externally).
// Latency: expectations derive from bit time = 16*(div+1) clocks measured on the serial line.
// Backpressure: TX requests wait for ready; every received word is queued by a monitor and compared in order.
module tb_uart_core;
    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        rstf = 1'b0;
    logic [15:0] div = 16'd26;
    logic        par_en = 1'b0, par_odd = 1'b0, two_stop = 1'b0, lb = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_vld = 1'b0, tx_rdy, tx_o;
    logic        rx_i = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_vld, rx_ferr, rx_perr;
    logic [4:0]  tx5_data = '0;
    logic        tx5_vld = 1'b0, tx5_rdy, tx5_o;
    logic [4:0]  rx5_data;
    logic        rx5_vld, rx5_ferr, rx5_perr;

    always #5 clk = ~clk;

    uart_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .DIV_WIDTH(16)) u_dut (
        .I_CLK(clk), .I_RSTF(rstf), .I_BAUD_DIV(div), .I_PARITY_EN(par_en), .I_PARITY_ODD(par_odd),
        .I_TWO_STOP(two_stop), .I_LOOPBACK(lb), .I_TX_DATA(tx_data), .I_TX_VALID(tx_vld),
        .O_TX_READY(tx_rdy), .O_TX(tx_o), .I_RX(rx_i), .O_RX_DATA(rx_data), .O_RX_VALID(rx_vld),
        .O_RX_FRAME_ERR(rx_ferr), .O_RX_PARITY_ERR(rx_perr));

    uart_core #(.DATA_BITS(5), .OVERSAMPLE(OS), .DIV_WIDTH(16)) u_dut5 (
        .I_CLK(clk), .I_RSTF(rstf), .I_BAUD_DIV(div), .I_PARITY_EN(par_en), .I_PARITY_ODD(par_odd),
        .I_TWO_STOP(two_stop), .I_LOOPBACK(1'b0), .I_TX_DATA(tx5_data), .I_TX_VALID(tx5_vld),
        .O_TX_READY(tx5_rdy), .O_TX(tx5_o), .I_RX(tx5_o), .O_RX_DATA(rx5_data), .O_RX_VALID(rx5_vld),
        .O_RX_FRAME_ERR(rx5_ferr), .O_RX_PARITY_ERR(rx5_perr));

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int flag_viol = 0, lb_tx_low = 0;
    logic [9:0] rxq[$];
    logic [6:0] rx5q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_vld === 1'b1) rxq.push_back({rx_ferr, rx_perr, rx_data});
        else if (rx_ferr !== 1'b0 || rx_perr !== 1'b0) flag_viol++;
        if (rx5_vld === 1'b1) rx5q.push_back({rx5_ferr, rx5_perr, rx5_data});
        if (lb === 1'b1 && tx_o !== 1'b1) lb_tx_low++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic logic line_of(input bit five);
        return five ? tx5_o : tx_o;
    endfunction

    function automatic logic rdy_of(input bit five);
        return five ? tx5_rdy : tx_rdy;
    endfunction

    // Parity bit: XOR of the data bits, inverted for odd parity.
    function automatic logic par_of(input logic [7:0] d, input int nbits);
        logic p = par_odd;
        for (int i = 0; i < nbits; i++) p = p ^ d[i];
        return p;
    endfunction

    // Serial frame, first bit on the wire at index 0; unused upper bits stay idle-high.
    function automatic logic [15:0] frame_of(input logic [7:0] d, input int nbits, input bit flip);
        logic [15:0] f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < nbits; i++) f[1 + i] = d[i];
        if (par_en) f[1 + nbits] = par_of(d, nbits) ^ flip;
        return f;
    endfunction

    function automatic int frame_len(input int nbits);
        return 2 + nbits + (par_en ? 1 : 0) + (two_stop ? 1 : 0);
    endfunction

    task automatic wait_tx_idle();
        int k = 0;
        while ((tx_rdy !== 1'b1 || tx5_rdy !== 1'b1) && k < 20000) begin @(negedge clk); k++; end
    endtask

    task automatic tx_send(input bit five, input logic [7:0] d, output int acc_c);
        int k = 0;
        @(negedge clk);
        while (rdy_of(five) !== 1'b1 && k < 20000) begin @(negedge clk); k++; end
        chk("tx_ready_before_send", rdy_of(five), 1);
        if (five) begin tx5_data = d[4:0]; tx5_vld = 1'b1; end
        else begin tx_data = d; tx_vld = 1'b1; end
        @(negedge clk);
        tx_vld = 1'b0;
        tx5_vld = 1'b0;
        acc_c = cyc;
        chk("tx_ready_drop", rdy_of(five), 0);
    endtask

    // Sends one word and checks every bit on the line for its full bit time, then ready timing.
    task automatic tx_frame(input bit five, input logic [7:0] d);
        int acc_c, fall_c, bt, nb, nbits, k;
        logic [15:0] fr;
        logic a, b;
        nbits = five ? 5 : 8;
        bt = OS * (int'(div) + 1);
        fr = frame_of(d, nbits, 1'b0);
        nb = frame_len(nbits);
        tx_send(five, d, acc_c);
        k = 0;
        while (line_of(five) !== 1'b0 && k < int'(div) + 4) begin @(negedge clk); k++; end
        fall_c = cyc;
        chk("tx_fall_delay", (fall_c - acc_c >= 1) && (fall_c - acc_c <= int'(div) + 2), 1);
        for (int i = 0; i < nb; i++) begin
            wait_until(fall_c + i * bt);
            a = line_of(five);
            wait_until(fall_c + i * bt + bt - 1);
            b = line_of(five);
            chk($sformatf("tx_bit%0d_d%0h", i, d), {a, b}, {fr[i], fr[i]});
        end
        chk("tx_ready_low_in_last_stop", rdy_of(five), 0);
        wait_until(fall_c + nb * bt);
        chk("tx_ready_after_frame", rdy_of(five), 1);
    endtask

    task automatic drive_rx(input logic [7:0] d, input bit flip);
        int bt = OS * (int'(div) + 1);
        int nb = frame_len(8);
        logic [15:0] fr = frame_of(d, 8, flip);
        for (int i = 0; i < nb; i++) begin
            rx_i = fr[i];
            repeat (bt) @(negedge clk);
        end
        rx_i = 1'b1;
    endtask

    task automatic rx_expect(input string tag, input logic [9:0] exp);
        logic [9:0] obs = 'x;
        int k = 0;
        int lim = 24 * OS * (int'(div) + 1);
        while (rxq.size() == 0 && k < lim) begin @(negedge clk); k++; end
        if (rxq.size() != 0) obs = rxq.pop_front();
        chk(tag, obs, exp);
    endtask

    initial begin
        logic [7:0] d;
        logic       flip;
        int         acc, k;
        logic [6:0] w5;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_o, 1);
        chk("rst_tx_ready", tx_rdy, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_vld, 0);
        chk("rst_rx_flags", {rx_ferr, rx_perr}, 0);
        rstf = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 0x55 at div 26: 432-clock bits, ready back exactly 10 bit times after the falling edge
        tx_frame(1'b0, 8'h55);

        // 150-clock low glitch is shorter than half a bit: no word, even after a full frame time
        @(negedge clk);
        rx_i = 1'b0;
        repeat (150) @(negedge clk);
        rx_i = 1'b1;
        repeat (11 * 432) @(negedge clk);
        chk("glitch_no_valid", rxq.size(), 0);
        div = 16'd3;
        drive_rx(8'hE7, 1'b0);
        rx_expect("rx_after_glitch", {2'b00, 8'hE7});

        // Loopback 8E1 0xA5
        par_en = 1'b1; par_odd = 1'b0; lb = 1'b1;
        tx_send(1'b0, 8'hA5, acc);
        rx_expect("lb_A5", {2'b00, 8'hA5});
        wait_tx_idle();
        repeat (20) @(negedge clk);
        chk("lb_single_pulse", rxq.size(), 0);

        // Randomized loopback frames
        for (int i = 0; i < 10; i++) begin
            wait_tx_idle();
            d = 8'($urandom);
            div = 16'($urandom_range(1, 4));
            par_en = 1'($urandom_range(0, 1));
            par_odd = 1'($urandom_range(0, 1));
            two_stop = 1'($urandom_range(0, 1));
            tx_send(1'b0, d, acc);
            rx_expect($sformatf("lb_rand%0d", i), {2'b00, d});
        end
        wait_tx_idle();
        lb = 1'b0;
        chk("lb_tx_held_high", lb_tx_low, 0);

        // Randomized TX line checks
        for (int i = 0; i < 4; i++) begin
            div = 16'($urandom_range(1, 4));
            par_en = 1'(i % 2);
            par_odd = 1'($urandom_range(0, 1));
            two_stop = 1'($urandom_range(0, 1));
            tx_frame(1'b0, 8'($urandom));
        end

        // Randomized RX frames, some with a corrupted parity bit
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            div = 16'($urandom_range(1, 4));
            par_en = 1'($urandom_range(0, 1));
            par_odd = 1'($urandom_range(0, 1));
            two_stop = 1'($urandom_range(0, 1));
            flip = par_en & 1'($urandom_range(0, 1));
            drive_rx(d, flip);
            rx_expect($sformatf("rx_rand%0d", i), {1'b0, flip, d});
        end

        // 8O1 0x01 with parity bit forced to 1, then a clean frame
        div = 16'd3; par_en = 1'b1; par_odd = 1'b1; two_stop = 1'b0;
        drive_rx(8'h01, 1'b1);
        rx_expect("rx_parity_err", {2'b01, 8'h01});
        drive_rx(8'h01, 1'b0);
        rx_expect("rx_parity_ok", {2'b00, 8'h01});

        // Break: 20 bit times low gives one frame-error word
        par_en = 1'b0;
        rx_i = 1'b0;
        repeat (20 * 64) @(negedge clk);
        rx_i = 1'b1;
        repeat (2 * 64) @(negedge clk);
        chk("break_word_count", rxq.size(), 1);
        rx_expect("break_word", {2'b10, 8'h00});
        drive_rx(8'h5A, 1'b0);
        rx_expect("rx_after_break", {2'b00, 8'h5A});

        // Async reset in the middle of a TX data bit
        two_stop = 1'b1;
        tx_send(1'b0, 8'hC3, acc);
        k = 0;
        while (tx_o !== 1'b0 && k < 10) begin @(negedge clk); k++; end
        repeat (3 * 64) @(negedge clk);
        #3 rstf = 1'b0;
        #1;
        chk("midrst_tx", tx_o, 1);
        chk("midrst_tx_ready", tx_rdy, 1);
        chk("midrst_rx_data", rx_data, 0);
        chk("midrst_rx_valid", rx_vld, 0);
        repeat (2) @(negedge clk);
        rstf = 1'b1;
        tx_frame(1'b0, 8'h3C);
        chk("midrst_no_rx_word", rxq.size(), 0);

        // 5-bit build: 0x15 on the wire as 5 data bits, received by its own RX
        two_stop = 1'b0;
        tx_frame(1'b1, 8'h15);
        w5 = 'x;
        if (rx5q.size() != 0) w5 = rx5q.pop_front();
        chk("dut5_rx_word", w5, {2'b00, 5'h15});

        chk("flags_zero_without_valid", flag_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
